// File: rtl/sound_square_gen_pkg.sv
// Shared sound-channel definitions.
// Holds the duty-select encoding, the four 8-step duty waveforms and the
// frequency-timer reload point used by the square-wave channels.
package sound_square_gen_pkg;

  typedef enum logic [1:0] {
    DUTY_12_5 = 2'd0,
    DUTY_25   = 2'd1,
    DUTY_50   = 2'd2,
    DUTY_75   = 2'd3
  } duty_e;

  // Timer value at which the period ends and the timer reloads.
  localparam logic [10:0] FREQ_RELOAD = 11'h7FF;

  // One 8-bit pattern per duty setting; bit index is the duty step.
  localparam logic [3:0][7:0] DUTY_WAVE = {
    8'b0111_1110,  // 75%
    8'b1000_0111,  // 50%
    8'b1000_0001,  // 25%
    8'b0000_0001   // 12.5%
  };

  function automatic logic duty_wave_bit(input duty_e duty, input logic [2:0] step);
    return DUTY_WAVE[duty][step];
  endfunction

endpackage

// File: rtl/sound_square_gen_if.sv
// Register/control bundle of a square-wave tone channel.
// master : register file / sequencer side (drives strobes, trigger, settings)
// slave  : tone generator (returns level sample and enabled flag)
// Signals: clk_freq_div, clk_length_ctr, start, frequency[10:0], duty,
//          length[LEN_BITS-1:0], single, target_vol[3:0] -> generator
//          level[3:0], enabled                          <- generator
interface sound_square_gen_if
  import sound_square_gen_pkg::*;
#(
  parameter int LEN_BITS = 6
);

  logic                clk_freq_div;
  logic                clk_length_ctr;
  logic                start;
  logic [10:0]         frequency;
  duty_e               duty;
  logic [LEN_BITS-1:0] length;
  logic                single;
  logic [3:0]          target_vol;
  logic [3:0]          level;
  logic                enabled;

  modport master (
    output clk_freq_div, clk_length_ctr, start, frequency, duty, length,
           single, target_vol,
    input  level, enabled
  );

  modport slave (
    input  clk_freq_div, clk_length_ctr, start, frequency, duty, length,
           single, target_vol,
    output level, enabled
  );

endinterface

// File: rtl/sound_length_ctr.sv
// Length counter shared by the sound channels.
// Loads 2^LEN_BITS - length on start and counts down on each length strobe
// while single is set; the channel disables itself when the count reaches 0.
// Ports:
//   clk, rst (async, active-high)
//   start          : (re)load counter and enable channel; masks strobes
//   length         : load value t
//   single         : 1 = counting enabled, channel stops at expiry
//   clk_length_ctr : 256 Hz one-cycle strobe
//   expire         : one-cycle pulse in the cycle the counter reaches 0
//   enabled        : channel active flag
module sound_length_ctr #(
  parameter int LEN_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_BITS-1:0] length,
  input  logic                single,
  input  logic                clk_length_ctr,
  output logic                expire,
  output logic                enabled
);

  localparam int CNT_W = LEN_BITS + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1) << LEN_BITS;

  logic [CNT_W-1:0] left_q, left_d;
  logic             en_q, en_d;
  logic             tick;

  // A start in the same cycle wins over the strobe.
  assign tick = clk_length_ctr && single && en_q && !start;

  always_comb begin
    left_d = left_q;
    en_d   = en_q;
    expire = 1'b0;
    if (start) begin
      left_d = FULL_CNT - CNT_W'(length);
      en_d   = 1'b1;
    end else if (tick && (left_q != '0)) begin
      left_d = left_q - CNT_W'(1);
      if (left_q == CNT_W'(1)) begin
        en_d   = 1'b0;
        expire = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q <= '0;
      en_q   <= 1'b0;
    end else begin
      left_q <= left_d;
      en_q   <= en_d;
    end
  end

  assign enabled = en_q;

endmodule

// File: rtl/sound_square_gen.sv
// Square-wave tone generator for channels 1 and 2.
// Gates the envelope stage's target_vol with a duty waveform stepped by an
// 11-bit frequency timer, and stops the channel through the length counter.
// Ports:
//   clk, rst (async, active-high)
//   bus (slave) : strobes, start, frequency, duty, length, single,
//                 target_vol in; registered level and enabled out
module sound_square_gen
  import sound_square_gen_pkg::*;
#(
  parameter int LEN_BITS = 6
) (
  input  logic               clk,
  input  logic               rst,
  sound_square_gen_if.slave  bus
);

  logic [10:0] timer_q, timer_d;
  logic [2:0]  step_q, step_d;
  logic [3:0]  level_q, level_d;
  logic        enabled;
  logic        wave_bit;
  // Square channels have no consumer for the expiry pulse.
  logic        len_expire_unused;

  sound_length_ctr #(
    .LEN_BITS(LEN_BITS)
  ) u_length_ctr (
    .clk            (clk),
    .rst            (rst),
    .start          (bus.start),
    .length         (bus.length),
    .single         (bus.single),
    .clk_length_ctr (bus.clk_length_ctr),
    .expire         (len_expire_unused),
    .enabled        (enabled)
  );

  // Frequency timer counts up from the programmed value; each wrap advances
  // the duty step. frequency is only sampled on start or at reload, so a
  // mid-period change waits for the next period.
  always_comb begin
    timer_d = timer_q;
    step_d  = step_q;
    if (bus.start) begin
      timer_d = bus.frequency;
      step_d  = 3'd0;
    end else if (bus.clk_freq_div && enabled) begin
      if (timer_q == FREQ_RELOAD) begin
        timer_d = bus.frequency;
        step_d  = step_q + 3'd1;
      end else begin
        timer_d = timer_q + 11'd1;
      end
    end
  end

  assign wave_bit = duty_wave_bit(bus.duty, step_q);
  assign level_d  = (enabled && wave_bit) ? bus.target_vol : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= 11'd0;
      step_q  <= 3'd0;
      level_q <= 4'd0;
    end else begin
      timer_q <= timer_d;
      step_q  <= step_d;
      level_q <= level_d;
    end
  end

  assign bus.level   = level_q;
  assign bus.enabled = enabled;

endmodule

// File: tb/tb_sound_square_gen.sv
module tb_sound_square_gen;
  import sound_square_gen_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  sound_square_gen_if #(.LEN_BITS(6)) bus ();

  sound_square_gen #(.LEN_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic freq_strobe();
    bus.clk_freq_div = 1'b1;
    cyc();
    bus.clk_freq_div = 1'b0;
  endtask

  task automatic len_strobe();
    bus.clk_length_ctr = 1'b1;
    cyc();
    bus.clk_length_ctr = 1'b0;
  endtask

  task automatic test_reset();
    // Power-on reset state.
    n_tests++;
    if (bus.level !== 4'h0) begin
      n_fail++; $display("FAIL por_level: got %h want 0", bus.level);
    end
    n_tests++;
    if (bus.enabled !== 1'b0) begin
      n_fail++; $display("FAIL por_enabled: got %b want 0", bus.enabled);
    end
    rst = 1'b0;
    bus.duty = DUTY_50; bus.frequency = 11'd2046; bus.target_vol = 4'hA;
    bus.single = 1'b0; bus.length = 6'd0;
    pulse_start();
    cyc();
    n_tests++;
    if (bus.level !== 4'hA) begin
      n_fail++; $display("FAIL rst_tone_level: got %h want a", bus.level);
    end
    // 6 strobes at f=2046 -> step 3, which is low for 50%.
    repeat (6) freq_strobe();
    cyc();
    n_tests++;
    if (bus.level !== 4'h0 || bus.enabled !== 1'b1) begin
      n_fail++; $display("FAIL rst_step3: got lvl %h en %b want 0/1", bus.level, bus.enabled);
    end
    repeat (2) freq_strobe();
    cyc();
    // step 4? no: 8 strobes -> step 4 (low). Move back to a high step first.
    repeat (6) freq_strobe();
    cyc();
    // 14 strobes -> step 7 (high).
    n_tests++;
    if (bus.level !== 4'hA) begin
      n_fail++; $display("FAIL rst_step7: got %h want a", bus.level);
    end
    // Asynchronous reset mid-tone, away from the clock edge.
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.level !== 4'h0 || bus.enabled !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got lvl %h en %b want 0/0", bus.level, bus.enabled);
    end
    cyc();
    rst = 1'b0;
    // Strobes while disabled are ignored.
    repeat (4) freq_strobe();
    cyc();
    n_tests++;
    if (bus.level !== 4'h0 || bus.enabled !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: got lvl %h en %b want 0/0", bus.level, bus.enabled);
    end
    // Restart with 12.5%: only step 0 is high, so A proves step returned to 0.
    bus.duty = DUTY_12_5;
    pulse_start();
    n_tests++;
    if (bus.level !== 4'h0 || bus.enabled !== 1'b1) begin
      n_fail++; $display("FAIL rst_restart_lat: got lvl %h en %b want 0/1", bus.level, bus.enabled);
    end
    cyc();
    n_tests++;
    if (bus.level !== 4'hA) begin
      n_fail++; $display("FAIL rst_restart: got %h want a", bus.level);
    end
  endtask

  task automatic test_duty50();
    logic [3:0] exp50 [8];
    exp50 = '{4'hA, 4'hA, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA};
    bus.duty = DUTY_50; bus.frequency = 11'd2046; bus.target_vol = 4'hA;
    bus.single = 1'b0;
    pulse_start();
    cyc();
    n_tests++;
    if (bus.level !== exp50[0]) begin
      n_fail++; $display("FAIL d50_step0: got %h want %h", bus.level, exp50[0]);
    end
    for (int n = 1; n <= 16; n++) begin
      freq_strobe();
      // Output still reflects the step before this strobe.
      n_tests++;
      if (bus.level !== exp50[((n - 1) / 2) % 8]) begin
        n_fail++; $display("FAIL d50_lat n=%0d: got %h want %h", n, bus.level, exp50[((n - 1) / 2) % 8]);
      end
      cyc();
      n_tests++;
      if (bus.level !== exp50[(n / 2) % 8]) begin
        n_fail++; $display("FAIL d50_seq n=%0d: got %h want %h", n, bus.level, exp50[(n / 2) % 8]);
      end
    end
    // Back at step 0; volume change appears one cycle later.
    bus.target_vol = 4'h3;
    cyc();
    n_tests++;
    if (bus.level !== 4'h3) begin
      n_fail++; $display("FAIL d50_vol: got %h want 3", bus.level);
    end
  endtask

  task automatic test_duty125();
    logic [3:0] exp_lvl;
    bus.duty = DUTY_12_5; bus.frequency = 11'd2047; bus.target_vol = 4'h7;
    bus.single = 1'b0;
    pulse_start();
    cyc();
    n_tests++;
    if (bus.level !== 4'h7) begin
      n_fail++; $display("FAIL d12_step0: got %h want 7", bus.level);
    end
    for (int n = 1; n <= 8; n++) begin
      freq_strobe();
      cyc();
      exp_lvl = (n == 8) ? 4'h7 : 4'h0;
      n_tests++;
      if (bus.level !== exp_lvl) begin
        n_fail++; $display("FAIL d12_seq n=%0d: got %h want %h", n, bus.level, exp_lvl);
      end
    end
    // At step 0: 75% pattern has bit0 low, bit1 high.
    bus.duty = DUTY_75;
    cyc();
    n_tests++;
    if (bus.level !== 4'h0) begin
      n_fail++; $display("FAIL d75_switch: got %h want 0", bus.level);
    end
    freq_strobe();
    cyc();
    n_tests++;
    if (bus.level !== 4'h7) begin
      n_fail++; $display("FAIL d75_step1: got %h want 7", bus.level);
    end
  endtask

  task automatic test_length();
    bus.duty = DUTY_50; bus.frequency = 11'd2046; bus.target_vol = 4'hA;
    bus.single = 1'b1; bus.length = 6'd62;
    pulse_start();
    cyc();
    n_tests++;
    if (bus.level !== 4'hA || bus.enabled !== 1'b1) begin
      n_fail++; $display("FAIL len62_start: got lvl %h en %b want a/1", bus.level, bus.enabled);
    end
    len_strobe();
    n_tests++;
    if (bus.enabled !== 1'b1) begin
      n_fail++; $display("FAIL len62_first: got en %b want 1", bus.enabled);
    end
    len_strobe();
    n_tests++;
    if (bus.enabled !== 1'b0 || bus.level !== 4'hA) begin
      n_fail++; $display("FAIL len62_expire: got lvl %h en %b want a/0", bus.level, bus.enabled);
    end
    cyc();
    n_tests++;
    if (bus.level !== 4'h0) begin
      n_fail++; $display("FAIL len62_level: got %h want 0", bus.level);
    end
    bus.length = 6'd0;
    pulse_start();
    repeat (63) len_strobe();
    n_tests++;
    if (bus.enabled !== 1'b1) begin
      n_fail++; $display("FAIL len0_63: got en %b want 1", bus.enabled);
    end
    len_strobe();
    n_tests++;
    if (bus.enabled !== 1'b0) begin
      n_fail++; $display("FAIL len0_64: got en %b want 0", bus.enabled);
    end
  endtask

  task automatic test_no_stop();
    bus.duty = DUTY_12_5; bus.frequency = 11'd2046; bus.target_vol = 4'h9;
    bus.single = 1'b0; bus.length = 6'd63;
    pulse_start();
    repeat (100) len_strobe();
    n_tests++;
    if (bus.enabled !== 1'b1 || bus.level !== 4'h9) begin
      n_fail++; $display("FAIL nostop: got lvl %h en %b want 9/1", bus.level, bus.enabled);
    end
    // 7 strobes -> step 3, timer parked at 2047.
    repeat (7) freq_strobe();
    cyc();
    n_tests++;
    if (bus.level !== 4'h0) begin
      n_fail++; $display("FAIL nostop_step3: got %h want 0", bus.level);
    end
    pulse_start();
    cyc();
    n_tests++;
    if (bus.level !== 4'h9) begin
      n_fail++; $display("FAIL restart_step0: got %h want 9", bus.level);
    end
    // Timer reloaded to 2046: one strobe must not advance the step.
    freq_strobe();
    cyc();
    n_tests++;
    if (bus.level !== 4'h9) begin
      n_fail++; $display("FAIL restart_timer: got %h want 9", bus.level);
    end
    freq_strobe();
    cyc();
    n_tests++;
    if (bus.level !== 4'h0) begin
      n_fail++; $display("FAIL restart_step1: got %h want 0", bus.level);
    end
  endtask

  task automatic test_coincident();
    bus.duty = DUTY_12_5; bus.frequency = 11'd2046; bus.target_vol = 4'h5;
    bus.single = 1'b1; bus.length = 6'd62;
    bus.start = 1'b1; bus.clk_freq_div = 1'b1; bus.clk_length_ctr = 1'b1;
    cyc();
    bus.start = 1'b0; bus.clk_freq_div = 1'b0; bus.clk_length_ctr = 1'b0;
    n_tests++;
    if (bus.enabled !== 1'b1) begin
      n_fail++; $display("FAIL coin_en: got %b want 1", bus.enabled);
    end
    cyc();
    n_tests++;
    if (bus.level !== 4'h5) begin
      n_fail++; $display("FAIL coin_step0: got %h want 5", bus.level);
    end
    freq_strobe();
    cyc();
    n_tests++;
    if (bus.level !== 4'h5) begin
      n_fail++; $display("FAIL coin_timer: got %h want 5", bus.level);
    end
    freq_strobe();
    cyc();
    n_tests++;
    if (bus.level !== 4'h0) begin
      n_fail++; $display("FAIL coin_step1: got %h want 0", bus.level);
    end
    len_strobe();
    n_tests++;
    if (bus.enabled !== 1'b1) begin
      n_fail++; $display("FAIL coin_len1: got en %b want 1", bus.enabled);
    end
    len_strobe();
    n_tests++;
    if (bus.enabled !== 1'b0) begin
      n_fail++; $display("FAIL coin_len2: got en %b want 0", bus.enabled);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.clk_freq_div = 1'b0; bus.clk_length_ctr = 1'b0; bus.start = 1'b0;
    bus.frequency = 11'd0; bus.duty = DUTY_12_5; bus.length = 6'd0;
    bus.single = 1'b0; bus.target_vol = 4'h0;
    repeat (3) cyc();
    test_reset();
    test_duty50();
    test_duty125();
    test_length();
    test_no_stop();
    test_coincident();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_square_gen.md
Name: sound_square_gen

Overview:
Square-wave tone generator for channels 1 and 2. It sits directly downstream of the volume-envelope stage: it consumes that stage's 4-bit target_vol and gates it with a duty-cycle waveform. It also owns the frequency timer and the length counter. Its level output feeds the channel mixer/DAC path.

Parameters:
LEN_BITS, 6, width of the length field; the length counter counts up to 2^LEN_BITS strobes.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
clk_freq_div  in  1  one-cycle strobe at 1048576 Hz; advances the frequency timer
clk_length_ctr  in  1  one-cycle strobe at 256 Hz; advances the length counter
start  in  1  one-cycle trigger; (re)starts the channel
frequency  in  11  NR13/NR14 frequency value f; one duty step takes (2048-f) freq strobes
duty  in  2  duty select (NRx1[7:6])
length  in  LEN_BITS  length load value t (NRx1[5:0])
single  in  1  length enable; 1 = stop the channel when the length counter expires
target_vol  in  4  current volume from the envelope stage
level  out  4  registered channel output sample
enabled  out  1  channel active flag (drives the NR52 status bit)

Behaviour:
- Reset (asynchronous, rst high): timer=0, duty_step=0, length_left=0, enabled=0, level=0. Clearing is immediate and holds while rst is high; this also applies mid-operation.
- Priority in any cycle: rst > start > strobes. A start coincident with either strobe ignores that strobe.
- On start:
  - timer <= frequency
  - duty_step <= 0
  - length_left <= 2^LEN_BITS - length, stored in LEN_BITS+1 bits; t=0 gives 64
  - enabled <= 1
- Frequency timer (11-bit up-counter), updated on clk_freq_div when enabled:
  - If timer==11'h7FF: timer <= frequency, and duty_step <= duty_step+1, wrapping modulo 8.
  - Else: timer <= timer+1.
  - A change to frequency mid-period takes effect only at the next reload.
  - f=2047 advances duty_step on every strobe.
- Duty waveforms, bit index = duty_step, MSB = step 7:
  - 00 -> 8'b0000_0001 (12.5%)
  - 01 -> 8'b1000_0001 (25%)
  - 10 -> 8'b1000_0111 (50%)
  - 11 -> 8'b0111_1110 (75%)
  - duty may change at any time; wave_bit is combinational from the current duty and duty_step.
- Length counter, updated on clk_length_ctr when single=1 and enabled=1:
  - If length_left != 0, decrement.
  - When the decrement reaches 0, enabled <= 0 in that same cycle.
  - With single=0 the counter holds and the channel never self-stops.
- Output: level <= (enabled && wave_bit) ? target_vol : 4'd0.
  - Registered; 1-cycle latency from a state or target_vol change.
  - After enabled falls, level is 0 from the next edge.
- Strobes while enabled=0 are ignored; timer, duty_step and length_left hold.

Decomposition:
- Shared sound package holds:
  - the DUTY_WAVE constants (four 8-bit patterns)
  - the duty encoding
  - the frequency reload value 11'h7FF
- One natural sub-module: sound_length_ctr.
  - Parameter LEN_BITS; ports clk, rst, start, length, single, clk_length_ctr.
  - Outputs expire pulse and enabled.
  - Reused later by channel 3 (LEN_BITS=8) and channel 4.
- The frequency timer and duty sequencer stay inline.

Test Plan:
- Reset state: rst pulse mid-tone -> level=0, enabled=0 in the same cycle; start after release restarts from duty_step=0.
- Duty 50%, frequency=2046, target_vol=4'hA, single=0, start, then 16 freq strobes:
  - duty_step advances every 2 strobes.
  - level sequence per step 0..7 is A,A,A,0,0,0,0,A.
  - Each level change appears 1 cycle after the advancing strobe.
- Duty 12.5%, frequency=2047: level=target_vol only on step 0, i.e. 1 of every 8 strobes. Change duty to 11 mid-run -> pattern switches on the next output cycle.
- Length expiry: single=1, length=62, start, 2 length strobes -> enabled falls on the 2nd strobe and level is 0 on the next edge. With length=0, expiry takes 64 strobes.
- single=0, length=63, 100 length strobes -> enabled stays 1. Re-start mid-tone -> timer reloads and duty_step returns to 0.
- start coincident with a clk_freq_div strobe and a clk_length_ctr strobe -> both strobes ignored; timer=frequency and length_left=2^LEN_BITS-length.
